// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the 3-to-8 decoder arbiter.
// FSM encoding, decoder enable patterns, requester mask helper.
package decoder_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  // Enable bundle ordering is {b0, b1, en2}.
  localparam logic [2:0] DEC_OFF = 3'b110;
  localparam logic [2:0] DEC_ON  = 3'b001;

  function automatic logic [7:0] req_mask(
    input int n
  );
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Requester/decoder bundle for decoder_rr_arbiter.
// master: arbiter (drives sel/enables/status); slave: requesters.
interface decoder_rr_arbiter_if;

  logic [7:0] req;
  logic [2:0] sel;
  logic       dec_en_b0;
  logic       dec_en_b1;
  logic       dec_en2;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       timeout;

  modport master (
    input  req,
    output sel,
    output dec_en_b0,
    output dec_en_b1,
    output dec_en2,
    output grant_valid,
    output grant_idx,
    output timeout
  );

  modport slave (
    output req,
    input  sel,
    input  dec_en_b0,
    input  dec_en_b1,
    input  dec_en2,
    input  grant_valid,
    input  grant_idx,
    input  timeout
  );

endinterface

// File: rtl/decoder_rr_arbiter_rr_pick8.sv
// rr_pick8: combinational rotating-priority picker.
// req_i (pre-masked), last_i -> any_o, idx_o (first set after last_i).
module rr_pick8 #(
  parameter int NREQ = 8
) (
  input  logic [7:0] req_i,
  input  logic [2:0] last_i,
  output logic       any_o,
  output logic [2:0] idx_o
);

  logic [3:0] cand;

  // Offsets 1..NREQ, so last_i itself is scanned last.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_i} + 4'(i);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      if (!any_o && req_i[cand[2:0]]) begin
        any_o = 1'b1;
        idx_o = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 74HC138-style decoder.
// clk, rst_n (async low); bus: req in; sel/enables/grant/timeout out.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int NREQ      = 8,
  parameter int GUARD_CYC = 1,
  parameter int MAX_HOLD  = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_rr_arbiter_if.master bus
);

  localparam logic [7:0] MASK = req_mask(NREQ);
  localparam logic [2:0] LAST_RST = 3'(NREQ - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam bit HOLD_LIM = (MAX_HOLD != 0);

  state_e           state_q;
  logic [2:0]       sel_q;
  logic [2:0]       last_q;
  logic [CNT_W-1:0] guard_q;
  logic [CNT_W-1:0] hold_q;
  logic [2:0]       en_q;
  logic             gv_q;
  logic             to_q;

  logic [7:0] req_m;
  logic [2:0] pick_last;
  logic [2:0] pick_idx;
  logic       pick_any;
  logic       cur_req;
  logic       rel;

  assign req_m   = bus.req & MASK;
  assign cur_req = req_m[sel_q];

  // On release the pointer moves to sel_q on the same edge,
  // so the next winner must already be ranked from sel_q.
  assign pick_last = (state_q == ST_GRANT) ? sel_q : last_q;

  assign rel = !cur_req ||
               (HOLD_LIM && (hold_q == HOLD_MAX));

  rr_pick8 #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i  (req_m),
    .last_i (pick_last),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= LAST_RST;
      guard_q <= '0;
      hold_q  <= '0;
      en_q    <= DEC_OFF;
      gv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            sel_q   <= pick_idx;
            guard_q <= GUARD_LD;
            state_q <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (guard_q != '0) begin
            guard_q <= guard_q - ONE;
          end else if (cur_req) begin
            en_q    <= DEC_ON;
            gv_q    <= 1'b1;
            hold_q  <= ONE;
            state_q <= ST_GRANT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            en_q   <= DEC_OFF;
            gv_q   <= 1'b0;
            last_q <= sel_q;
            hold_q <= '0;
            // Still requesting here means the hold limit hit.
            to_q   <= cur_req;
            if (pick_any) begin
              sel_q   <= pick_idx;
              guard_q <= GUARD_LD;
              state_q <= ST_GUARD;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (hold_q != '1) begin
            hold_q <= hold_q + ONE;
          end
        end
        default: begin
          en_q    <= DEC_OFF;
          gv_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sel         = sel_q;
  assign bus.grant_idx   = sel_q;
  assign bus.dec_en_b0   = en_q[2];
  assign bus.dec_en_b1   = en_q[1];
  assign bus.dec_en2     = en_q[0];
  assign bus.grant_valid = gv_q;
  assign bus.timeout     = to_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter with a 74HC138 model on its outputs.
// Per-cycle expectations queued on drive, popped after the edge.
module tb_decoder_rr_arbiter;

  typedef struct {
    logic [7:0] req;
    logic       gv;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dec_y_n;
  int         n_chk = 0;
  int         n_fail = 0;
  vec_t       vecs[$];
  vec_t       exp_q[$];

  decoder_rr_arbiter_if bus();

  decoder_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // 74HC138: all outputs high unless G1=1, G2A=G2B=0.
  always_comb begin
    dec_y_n = 8'hFF;
    if (bus.dec_en2 && !bus.dec_en_b0 && !bus.dec_en_b1) begin
      dec_y_n[bus.sel] = 1'b0;
    end
  end

  task automatic chk(
    input string      nm,
    input int         stp,
    input logic [7:0] got,
    input logic [7:0] want
  );
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %h, want %h",
               nm, stp, got, want);
    end
  endtask

  task automatic cmp(input vec_t e, input int stp);
    logic [7:0] yn;
    logic [2:0] en;
    yn = e.gv ? ~(8'h01 << e.idx) : 8'hFF;
    en = e.gv ? 3'b001 : 3'b110;
    chk("sel", stp, 8'(bus.sel), 8'(e.idx));
    chk("grant_idx", stp, 8'(bus.grant_idx), 8'(e.idx));
    chk("grant_valid", stp, 8'(bus.grant_valid), 8'(e.gv));
    chk("enables", stp,
        8'({bus.dec_en_b0, bus.dec_en_b1, bus.dec_en2}),
        8'(en));
    chk("timeout", stp, 8'(bus.timeout), 8'(e.to));
    chk("dec_y_n", stp, dec_y_n, yn);
  endtask

  function automatic vec_t mk(
    input logic [7:0] r,
    input logic       g,
    input logic [2:0] i,
    input logic       t
  );
    vec_t v;
    v.req = r;
    v.gv  = g;
    v.idx = i;
    v.to  = t;
    return v;
  endfunction

  task automatic addn(
    input int         n,
    input logic [7:0] r,
    input logic       g,
    input logic [2:0] i,
    input logic       t
  );
    repeat (n) vecs.push_back(mk(r, g, i, t));
  endtask

  task automatic step(input vec_t v, input int stp);
    bus.req = v.req;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    cmp(exp_q.pop_front(), stp);
  endtask

  initial begin
    rst_n   = 1'b1;
    bus.req = '0;

    // Reset asserted between edges; outputs must clear at once.
    #7 rst_n = 1'b0;
    #1;
    cmp(mk(8'h00, 1'b0, 3'd0, 1'b0), 0);
    chk("dec_active", 0, ~dec_y_n, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0, release after 2 grant cycles.
    addn(1, 8'h01, 0, 0, 0);
    addn(2, 8'h01, 1, 0, 0);
    addn(2, 8'h00, 0, 0, 0);
    // 1 and 3 alternate, 3 grant cycles each.
    addn(1, 8'h0A, 0, 1, 0);
    addn(3, 8'h0A, 1, 1, 0);
    addn(1, 8'h08, 0, 3, 0);
    addn(3, 8'h0A, 1, 3, 0);
    addn(1, 8'h02, 0, 1, 0);
    addn(3, 8'h0A, 1, 1, 0);
    addn(1, 8'h08, 0, 3, 0);
    addn(3, 8'h0A, 1, 3, 0);
    addn(1, 8'h00, 0, 3, 0);
    // Requester 7 held: 16-cycle grant, timeout, re-grant.
    addn(1, 8'h80, 0, 7, 0);
    addn(16, 8'h80, 1, 7, 0);
    addn(1, 8'h80, 0, 7, 1);
    addn(1, 8'h80, 1, 7, 0);
    addn(2, 8'h00, 0, 7, 0);
    // 0 and 2 from last=7; 0 drops after grant cycle 2.
    addn(1, 8'h05, 0, 0, 0);
    addn(2, 8'h05, 1, 0, 0);
    addn(1, 8'h04, 0, 2, 0);
    addn(1, 8'h04, 1, 2, 0);
    addn(2, 8'h00, 0, 2, 0);
    // req[4] gone during guard: no grant, pointer stays 2.
    addn(1, 8'h10, 0, 4, 0);
    addn(2, 8'h00, 0, 4, 0);
    addn(1, 8'h09, 0, 3, 0);
    addn(1, 8'h09, 1, 3, 0);
    addn(2, 8'h00, 0, 3, 0);

    foreach (vecs[i]) step(vecs[i], i + 1);

    // Reset in the middle of a grant to 4.
    step(mk(8'h10, 1'b0, 3'd4, 1'b0), 200);
    step(mk(8'h10, 1'b1, 3'd4, 1'b0), 201);
    #2 rst_n = 1'b0;
    #1;
    cmp(mk(8'h10, 1'b0, 3'd0, 1'b0), 202);
    @(negedge clk);
    rst_n = 1'b1;
    // Pointer back at 7: requester 0 beats 7.
    step(mk(8'h81, 1'b0, 3'd0, 1'b0), 203);
    step(mk(8'h81, 1'b1, 3'd0, 1'b0), 204);
    step(mk(8'h80, 1'b0, 3'd7, 1'b0), 205);
    step(mk(8'h80, 1'b1, 3'd7, 1'b0), 206);
    step(mk(8'h00, 1'b0, 3'd7, 1'b0), 207);
    step(mk(8'h00, 1'b0, 3'd7, 1'b0), 208);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
